// File: rtl/collapsing_issue_queue.sv
// Age-ordered collapsing issue queue: slot index equals age (0 = oldest).
// Survivors compact toward slot 0 each cycle and new micro-ops are appended after them.
module collapsing_issue_queue #(
  parameter int DISPATCH_WIDTH   = 2,
  parameter int ISSUE_WIDTH      = 2,
  parameter int NUM_WAKEUP_PORTS = 2,
  parameter int NUM_ISSUE_SLOTS  = 8,
  parameter int PREG_W           = 7,
  parameter int CTRL_W           = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  flush,
  input  logic [DISPATCH_WIDTH-1:0]             dis_valid,
  output logic                                  dis_ready,
  input  logic [DISPATCH_WIDTH*PREG_W-1:0]      dis_src1,
  input  logic [DISPATCH_WIDTH-1:0]             dis_p1,
  input  logic [DISPATCH_WIDTH-1:0]             dis_v1,
  input  logic [DISPATCH_WIDTH*PREG_W-1:0]      dis_src2,
  input  logic [DISPATCH_WIDTH-1:0]             dis_p2,
  input  logic [DISPATCH_WIDTH-1:0]             dis_v2,
  input  logic [DISPATCH_WIDTH*CTRL_W-1:0]      dis_ctrl,
  input  logic [NUM_WAKEUP_PORTS-1:0]           wk_valid,
  input  logic [NUM_WAKEUP_PORTS*PREG_W-1:0]    wk_pdst,
  input  logic                                  iss_ready,
  output logic [ISSUE_WIDTH-1:0]                iss_valid,
  output logic [ISSUE_WIDTH*PREG_W-1:0]         iss_src1,
  output logic [ISSUE_WIDTH*PREG_W-1:0]         iss_src2,
  output logic [ISSUE_WIDTH*CTRL_W-1:0]         iss_ctrl,
  output logic [$clog2(NUM_ISSUE_SLOTS+1)-1:0]  count
);

  localparam int N     = NUM_ISSUE_SLOTS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(N + 1);

  typedef struct packed {
    logic [PREG_W-1:0] src1;
    logic              p1;
    logic              v1;
    logic [PREG_W-1:0] src2;
    logic              p2;
    logic              v2;
    logic [CTRL_W-1:0] ctrl;
  } slot_t;

  slot_t             slot_q [N];
  slot_t             slot_d [N];
  logic [N-1:0]      valid_q, valid_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [N-1:0]              rdy;
  logic [N-1:0]              taken;
  logic [N-1:0]              issued;
  logic [ISSUE_WIDTH-1:0]    lane_vld;
  logic [IDX_W-1:0]          lane_idx [ISSUE_WIDTH];
  logic [DISPATCH_WIDTH-1:0] accept;
  logic                      issue_fire;

  function automatic logic wake_hit(input logic [PREG_W-1:0]                 tag,
                                    input logic [NUM_WAKEUP_PORTS-1:0]        vld,
                                    input logic [NUM_WAKEUP_PORTS*PREG_W-1:0] pdst);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < NUM_WAKEUP_PORTS; j++) begin
      if (vld[j] && (pdst[j*PREG_W +: PREG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Handshakes: a dispatch lane transfers when dis_valid[i] & dis_ready & !flush;
  // the issue group transfers when iss_valid[k] & iss_ready (iss_valid is 0 during flush).
  assign dis_ready  = (count_q <= CNT_W'(N - DISPATCH_WIDTH));
  assign accept     = dis_valid & {DISPATCH_WIDTH{dis_ready & ~flush}};
  assign issue_fire = iss_ready & ~flush;
  assign issued     = taken & {N{issue_fire}};
  assign count      = count_q;

  always_comb begin
    rdy = '0;
    for (int s = 0; s < N; s++) begin
      rdy[s] = valid_q[s] & (~slot_q[s].v1 | slot_q[s].p1) & (~slot_q[s].v2 | slot_q[s].p2);
    end
  end

  // Lane k claims the lowest-index ready slot not already claimed by a lower lane.
  always_comb begin
    taken = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      lane_vld[k] = 1'b0;
      lane_idx[k] = '0;
      for (int s = 0; s < N; s++) begin
        if (!lane_vld[k] && rdy[s] && !taken[s]) begin
          lane_vld[k] = 1'b1;
          lane_idx[k] = s[IDX_W-1:0];
          taken[s]    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    iss_valid = '0;
    iss_src1  = '0;
    iss_src2  = '0;
    iss_ctrl  = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      iss_valid[k]                   = lane_vld[k] & ~flush;
      iss_src1[k*PREG_W +: PREG_W]   = slot_q[lane_idx[k]].src1;
      iss_src2[k*PREG_W +: PREG_W]   = slot_q[lane_idx[k]].src2;
      iss_ctrl[k*CTRL_W +: CTRL_W]   = slot_q[lane_idx[k]].ctrl;
    end
  end

  // Compaction: survivors keep age order from slot 0, accepted lanes follow in lane order.
  always_comb begin
    int    w;
    slot_t ns;
    valid_d = '0;
    count_d = '0;
    w       = 0;
    ns      = '0;
    for (int s = 0; s < N; s++) slot_d[s] = slot_q[s];
    for (int s = 0; s < N; s++) begin
      if (valid_q[s] && !issued[s]) begin
        ns    = slot_q[s];
        ns.p1 = slot_q[s].p1 | (slot_q[s].v1 & wake_hit(slot_q[s].src1, wk_valid, wk_pdst));
        ns.p2 = slot_q[s].p2 | (slot_q[s].v2 & wake_hit(slot_q[s].src2, wk_valid, wk_pdst));
        if (w < N) begin
          slot_d[w]  = ns;
          valid_d[w] = 1'b1;
        end
        w = w + 1;
      end
    end
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (accept[i]) begin
        ns.src1 = dis_src1[i*PREG_W +: PREG_W];
        ns.v1   = dis_v1[i];
        ns.p1   = dis_p1[i] | (dis_v1[i] & wake_hit(ns.src1, wk_valid, wk_pdst));
        ns.src2 = dis_src2[i*PREG_W +: PREG_W];
        ns.v2   = dis_v2[i];
        ns.p2   = dis_p2[i] | (dis_v2[i] & wake_hit(ns.src2, wk_valid, wk_pdst));
        ns.ctrl = dis_ctrl[i*CTRL_W +: CTRL_W];
        if (w < N) begin
          slot_d[w]  = ns;
          valid_d[w] = 1'b1;
        end
        w = w + 1;
      end
    end
    count_d = w[CNT_W-1:0];
    if (flush) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Payload storage is qualified by valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int s = 0; s < N; s++) slot_q[s] <= slot_d[s];
  end

endmodule
